// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_REGFILE     = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // x0 is hardwired zero, so it never produces a dependency
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs, input logic we);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// rtl/pipe_fwd_unit.sv - operand forward select for one execute-stage source
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // MEM holds the younger result, so it wins over WB
    always_comb begin
        fwd = FWD_REGFILE;
        if (reg_match(rd_m, rs, reg_write_m)) begin
            fwd = FWD_MEM;
        end else if (reg_match(rd_w, rs, reg_write_w)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward control with data-memory wait FSM
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteW,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemErr,
    output logic [31:0] StallCnt
);

    localparam logic [8:0] TIMEOUT_W = TIMEOUT[8:0];

    ctrl_state_t state, state_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic [8:0]  wait_inc;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_stall, load_use;

    pipe_fwd_unit u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    pipe_fwd_unit u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    assign wait_inc = {1'b0, wait_cnt} + 9'd1;

    // wait_cnt holds the number of stalled memory cycles already elapsed
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_RUN: begin
                if (MemReqM && !MemReadyM) begin
                    wait_cnt_next = 8'd1;
                    state_next    = (9'd1 >= TIMEOUT_W) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    wait_cnt_next = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (!MemReadyM) begin
                    wait_cnt_next = wait_inc[7:0];
                    state_next    = (wait_inc >= TIMEOUT_W) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    wait_cnt_next = 8'd0;
                    state_next    = ST_RUN;
                end
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_RUN;
        endcase
    end

    assign load_use = (ResultSrcE == RESULT_SRC_LOAD) &&
                      (reg_match(RdE, Rs1D, 1'b1) || reg_match(RdE, Rs2D, 1'b1));

    assign mem_stall = (state == ST_ERROR) ||
                       ((state == ST_RUN) && MemReqM && !MemReadyM) ||
                       ((state == ST_MEM_WAIT) && !MemReadyM);

    // priority: reset, then memory freeze, then branch flush, then load-use bubble
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_REGFILE;
        ForwardBE = FWD_REGFILE;
        if (!rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign MemErr = (state == ST_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt <= 32'd0;
        end else if (StallF && (StallCnt != 32'hFFFF_FFFF)) begin
            StallCnt <= StallCnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // reference: consecutive stalled memory cycles, error latch, stall counter
    int          m_consec = 0;
    bit          m_err = 0;
    logic [31:0] m_cnt = 0;

    initial begin : compare
        logic       stall, lu, ef, ed, ee, es;
        logic [6:0] exp_vec;
        forever begin
            @(negedge clk);
            stall = m_err || ((m_consec > 0) ? !MemReadyM : (MemReqM && !MemReadyM));
            lu    = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
            ef = 0; ed = 0; ee = 0; es = 0;
            if (stall)       es = 1;
            else if (PCSrcE) begin ed = 1; ee = 1; end
            else if (lu)     begin ef = 1; ee = 1; end
            exp_vec = rst ? 7'd0 : {es | ef, es | ef, es, es, es, ed, ee};
            check("ctl_vec", {25'd0, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, {25'd0, exp_vec});
            check("fwd_a", {30'd0, ForwardAE}, {30'd0, rst ? 2'b00 : model_fwd(Rs1E)});
            check("fwd_b", {30'd0, ForwardBE}, {30'd0, rst ? 2'b00 : model_fwd(Rs2E)});
            if (!rst) begin
                check("stall_cnt", StallCnt, m_cnt);
                check("mem_err", {31'd0, MemErr}, {31'd0, m_err});
            end
            if (rst) begin
                m_consec = 0; m_err = 0; m_cnt = 0;
            end else begin
                if (stall) begin
                    m_consec++;
                    if (m_consec >= TO) m_err = 1;
                end else begin
                    m_consec = 0;
                end
                if ((es | ef) && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end
        end
    end

    initial begin : stim
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // forwarding: MEM beats WB, WB alone, x0 never forwarded
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        @(negedge clk);
        check("s1_fwd_mem", {30'd0, ForwardAE}, 32'd2);
        check("s1_no_stall", {31'd0, StallF}, 32'd0);
        next_cycle();
        RdM = 3;
        @(negedge clk);
        check("s1_fwd_wb", {30'd0, ForwardAE}, 32'd1);
        next_cycle();
        RdM = 0; Rs1E = 0; RdW = 0;
        @(negedge clk);
        check("s1_fwd_x0", {30'd0, ForwardAE}, 32'd0);

        // load-use bubble
        next_cycle(); clear_inputs();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        @(negedge clk);
        check("s2_lu", {29'd0, StallF, StallD, FlushE}, 32'd7);
        check("s2_lu_e", {31'd0, StallE}, 32'd0);
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("s2_cnt", StallCnt, 32'd1);
        check("s2_release", {31'd0, StallF}, 32'd0);

        // branch flush suppresses load-use stall
        next_cycle();
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1;
        @(negedge clk);
        check("s3_br", {29'd0, FlushD, FlushE, StallF}, 32'd6);

        // memory wait of 3 cycles, held branch reasserts afterwards
        next_cycle(); clear_inputs();
        MemReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s4_stall", {25'd0, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 32'h7C);
            next_cycle();
        end
        MemReadyM = 1;
        @(negedge clk);
        check("s4_release", {25'd0, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 32'h03);
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("s4_run", {31'd0, StallE}, 32'd0);
        check("s4_cnt", StallCnt, 32'd4);

        // timeout into ERROR
        next_cycle();
        MemReqM = 1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("s5_pre_err", {31'd0, MemErr}, 32'd0);
            check("s5_stall", {31'd0, StallW}, 32'd1);
            next_cycle();
        end
        MemReadyM = 1; MemReqM = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s5_err", {30'd0, MemErr, StallF}, 32'd3);
            next_cycle();
        end

        // reset out of ERROR
        rst = 1;
        @(negedge clk);
        check("s6_rst_out", {30'd0, StallF, FlushE}, 32'd0);
        next_cycle();
        rst = 0; MemReqM = 1; MemReadyM = 1;
        @(negedge clk);
        check("s6_err", {31'd0, MemErr}, 32'd0);
        check("s6_cnt", StallCnt, 32'd0);
        check("s6_run", {31'd0, StallE}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemReqM   = ($urandom_range(0, 9) < 4);
            MemReadyM = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 49) == 0);
        end
        next_cycle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
